// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared types and width helpers for the systolic skew feeder.
//             Contents: FSM state enum, default operand width, and helpers
//             for lane-index, word-index and lane-counter widths.
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FEED = 1'b1
   } state_t;

   localparam int DEFAULT_DW = 8;

   // Lane index must address the wider of the two operand buffers.
   function automatic int lane_w(input int n, input int m);
      int mx;
      mx = (n > m) ? n : m;
      return (mx > 1) ? $clog2(mx) : 1;
   endfunction

   // Word index within a lane; at least one bit even for K=1.
   function automatic int idx_w(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

   // Lane counter has to represent K itself (the exhausted value).
   function automatic int cnt_w(input int k);
      return $clog2(k + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_skew_feeder_if
//  Purpose  : Bundles the controller enables, tile write port and the
//             skewed operand outputs of the systolic skew feeder.
//  Modports : master - controller / tile loader side (drives enables, load,
//                      write port, arm; observes feed outputs)
//             slave  - feeder side
//  Options  : SYSTOLIC_SKEW_FEEDER_ERR_EN adds the sticky 'err' output.
//  Revision : 1.0 - initial release
// ============================================================================
interface systolic_skew_feeder_if
   import systolic_pkg::*;
#(
   parameter int N  = 2,
   parameter int M  = 2,
   parameter int K  = 2,
   parameter int DW = DEFAULT_DW
);
   logic [N-1:0]          A_start_en;
   logic [M-1:0]          B_start_en;
   logic                  load;
   logic                  wr_en;
   logic                  wr_is_b;
   logic [lane_w(N,M)-1:0] wr_lane;
   logic [idx_w(K)-1:0]   wr_idx;
   logic [DW-1:0]         wr_data;
   logic                  arm;
   logic                  busy;
   logic [N*DW-1:0]       a_data;
   logic [N-1:0]          a_valid;
   logic [M*DW-1:0]       b_data;
   logic [M-1:0]          b_valid;
   logic                  done;
`ifdef SYSTOLIC_SKEW_FEEDER_ERR_EN
   logic                  err;
`endif

   modport master (
      output A_start_en, B_start_en, load, wr_en, wr_is_b, wr_lane, wr_idx,
             wr_data, arm,
      input  busy, a_data, a_valid, b_data, b_valid, done
`ifdef SYSTOLIC_SKEW_FEEDER_ERR_EN
      , input err
`endif
   );

   modport slave (
      input  A_start_en, B_start_en, load, wr_en, wr_is_b, wr_lane, wr_idx,
             wr_data, arm,
      output busy, a_data, a_valid, b_data, b_valid, done
`ifdef SYSTOLIC_SKEW_FEEDER_ERR_EN
      , output err
`endif
   );

endinterface
`default_nettype wire

// File: rtl/skew_feed_lane.sv
`default_nettype none
// ============================================================================
//  Module   : skew_feed_lane
//  Purpose  : One operand lane (A row or B column): K-word buffer with write
//             port, issue counter, registered data/valid output and an
//             exhausted flag reflecting the post-update counter value.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             wr_en/idx/data   - pre-qualified buffer write
//             clear            - zero the counter (feed start)
//             load_en          - advance pulse, already gated by FEED state
//             start_en         - controller start enable for this lane
//             data, valid      - registered lane output
//             exhausted        - counter equals K after this cycle's update
//  Revision : 1.0 - initial release
// ============================================================================
module skew_feed_lane
   import systolic_pkg::*;
#(
   parameter int K  = 2,
   parameter int DW = DEFAULT_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [idx_w(K)-1:0]  wr_idx,
   input  logic [DW-1:0]        wr_data,
   input  logic                 clear,
   input  logic                 load_en,
   input  logic                 start_en,
   output logic [DW-1:0]        data,
   output logic                 valid,
   output logic                 exhausted
);
   localparam int             IW    = idx_w(K);
   localparam int             CW    = cnt_w(K);
   localparam logic [CW-1:0]  C_MAX = CW'(K);

   // Storage is deliberately not reset: a tile survives a controller reset.
   logic [DW-1:0] r_mem [K];
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          w_issue;

   assign w_issue   = load_en && start_en && (r_cnt != C_MAX);
   assign w_cnt_nxt = r_cnt + CW'(w_issue);
   // Looks at the post-update count so the FSM can finish on the final load.
   assign exhausted = (w_cnt_nxt == C_MAX);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_issue;
         r_data  <= w_issue ? r_mem[r_cnt[IW-1:0]] : '0;
         if (clear) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_nxt;
         end
      end
   end

   assign data  = r_data;
   assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_skew_feeder
//  Purpose  : Holds one A tile (N rows x K words) and one B tile (M columns x
//             K words) and, on each controller load pulse, emits the next
//             word of every enabled lane, producing the diagonal operand skew
//             for a systolic PE array.
//  Ports    : clk, rst - clock, synchronous active-high reset
//             bus      - systolic_skew_feeder_if.slave (enables, load, tile
//                        write port, arm, busy, a/b data+valid, done)
//  Options  : SYSTOLIC_SKEW_FEEDER_ERR_EN - adds sticky 'err' flag for
//             dropped writes (write while feeding or out-of-range index).
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int N  = 2,
   parameter int M  = 2,
   parameter int K  = 2,
   parameter int DW = DEFAULT_DW
) (
   input  logic                    clk,
   input  logic                    rst,
   systolic_skew_feeder_if.slave   bus
);
   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_done;
   logic            w_done_nxt;
   logic            w_clear;
   logic            w_load_en;
   logic            w_idx_ok;
   logic            w_lane_ok;
   logic            w_wr_ok;
   logic            w_all_exh;
   logic [N-1:0]    w_a_exh;
   logic [M-1:0]    w_b_exh;
   logic [N*DW-1:0] w_a_data;
   logic [N-1:0]    w_a_valid;
   logic [M*DW-1:0] w_b_data;
   logic [M-1:0]    w_b_valid;

   // ---------------- write decode ----------------
   assign w_idx_ok  = int'(bus.wr_idx) < K;
   assign w_lane_ok = bus.wr_is_b ? (int'(bus.wr_lane) < M)
                                  : (int'(bus.wr_lane) < N);
   assign w_wr_ok   = (r_state == ST_IDLE) && bus.wr_en && w_idx_ok && w_lane_ok;

   // ---------------- lanes ----------------
   for (genvar i = 0; i < N; i++) begin : g_a_lane
      skew_feed_lane #(.K(K), .DW(DW)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (w_wr_ok && !bus.wr_is_b && (int'(bus.wr_lane) == i)),
         .wr_idx    (bus.wr_idx),
         .wr_data   (bus.wr_data),
         .clear     (w_clear),
         .load_en   (w_load_en),
         .start_en  (bus.A_start_en[i]),
         .data      (w_a_data[i*DW +: DW]),
         .valid     (w_a_valid[i]),
         .exhausted (w_a_exh[i])
      );
   end

   for (genvar j = 0; j < M; j++) begin : g_b_lane
      skew_feed_lane #(.K(K), .DW(DW)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (w_wr_ok && bus.wr_is_b && (int'(bus.wr_lane) == j)),
         .wr_idx    (bus.wr_idx),
         .wr_data   (bus.wr_data),
         .clear     (w_clear),
         .load_en   (w_load_en),
         .start_en  (bus.B_start_en[j]),
         .data      (w_b_data[j*DW +: DW]),
         .valid     (w_b_valid[j]),
         .exhausted (w_b_exh[j])
      );
   end

   assign w_all_exh = (&w_a_exh) && (&w_b_exh);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_clear     = 1'b0;
      w_load_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.arm) begin
               w_state_nxt = ST_FEED;
               w_clear     = 1'b1;
            end
         end
         ST_FEED: begin
            w_load_en = bus.load;
            // Finish on the load that leaves every lane counter at K, so
            // done and busy=0 line up with the last valid words.
            if (bus.load && w_all_exh) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- optional error flag ----------------
`ifdef SYSTOLIC_SKEW_FEEDER_ERR_EN
   logic w_drop;
   logic r_err;

   assign w_drop = bus.wr_en && !w_wr_ok;

   // A dropped write in the arm cycle still flags, so set wins over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_drop) begin
         r_err <= 1'b1;
      end else if (w_clear) begin
         r_err <= 1'b0;
      end
   end

   assign bus.err = r_err;
`endif

   // ---------------- outputs ----------------
   assign bus.busy    = (r_state == ST_FEED);
   assign bus.done    = r_done;
   assign bus.a_data  = w_a_data;
   assign bus.a_valid = w_a_valid;
   assign bus.b_data  = w_b_data;
   assign bus.b_valid = w_b_valid;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_skew_feeder
//  Purpose  : Self-checking bench for systolic_skew_feeder. A behavioural
//             model (tile arrays plus per-lane issued-word counts) predicts
//             every output each cycle; directed steps are followed by
//             randomized tiles, enables, gaps and stray writes.
//  Options  : SYSTOLIC_SKEW_FEEDER_ERR_EN also checks 'err'.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;
   import systolic_pkg::*;

   localparam int N  = 3;
   localparam int M  = 2;
   localparam int K  = 3;
   localparam int DW = 8;
   localparam int LW = lane_w(N, M);
   localparam int IW = idx_w(K);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_skew_feeder_if #(.N(N), .M(M), .K(K), .DW(DW)) bus ();

   systolic_skew_feeder #(.N(N), .M(M), .K(K), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- reference model state ----------------
   int  bufa [N][K];
   int  bufb [M][K];
   int  issued_a [N];
   int  issued_b [M];
   bit  m_busy;
   bit  m_err;
   logic [N*DW-1:0] exp_a;
   logic [N-1:0]    exp_av;
   logic [M*DW-1:0] exp_b;
   logic [M-1:0]    exp_bv;
   logic            exp_done;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] therm_a(input int p);
      logic [N-1:0] t;
      for (int i = 0; i < N; i++) t[i] = (i < p);
      return t;
   endfunction

   function automatic logic [M-1:0] therm_b(input int p);
      logic [M-1:0] t;
      for (int j = 0; j < M; j++) t[j] = (j < p);
      return t;
   endfunction

   task automatic clr();
      bus.A_start_en = '0;
      bus.B_start_en = '0;
      bus.load       = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_is_b    = 1'b0;
      bus.wr_lane    = '0;
      bus.wr_idx     = '0;
      bus.wr_data    = '0;
      bus.arm        = 1'b0;
   endtask

   // Predict the next cycle from the present inputs, clock once, compare.
   task automatic step();
      bit drop;
      bit all_out;
      int ln;
      int ix;
      drop     = 1'b0;
      exp_a    = '0;
      exp_av   = '0;
      exp_b    = '0;
      exp_bv   = '0;
      exp_done = 1'b0;
      ln = int'(bus.wr_lane);
      ix = int'(bus.wr_idx);
      if (rst) begin
         m_busy = 1'b0;
         m_err  = 1'b0;
         foreach (issued_a[i]) issued_a[i] = 0;
         foreach (issued_b[j]) issued_b[j] = 0;
      end else if (!m_busy) begin
         if (bus.wr_en) begin
            if (ix < K && (bus.wr_is_b ? (ln < M) : (ln < N))) begin
               if (bus.wr_is_b) bufb[ln][ix] = int'(bus.wr_data);
               else             bufa[ln][ix] = int'(bus.wr_data);
            end else begin
               drop = 1'b1;
            end
         end
         if (bus.arm) begin
            m_busy = 1'b1;
            foreach (issued_a[i]) issued_a[i] = 0;
            foreach (issued_b[j]) issued_b[j] = 0;
         end
         if (drop)         m_err = 1'b1;
         else if (bus.arm) m_err = 1'b0;
      end else begin
         if (bus.wr_en) m_err = 1'b1;
         if (bus.load) begin
            for (int i = 0; i < N; i++) begin
               if (bus.A_start_en[i] && issued_a[i] < K) begin
                  exp_av[i]          = 1'b1;
                  exp_a[i*DW +: DW]  = DW'(bufa[i][issued_a[i]]);
                  issued_a[i]++;
               end
            end
            for (int j = 0; j < M; j++) begin
               if (bus.B_start_en[j] && issued_b[j] < K) begin
                  exp_bv[j]          = 1'b1;
                  exp_b[j*DW +: DW]  = DW'(bufb[j][issued_b[j]]);
                  issued_b[j]++;
               end
            end
            all_out = 1'b1;
            foreach (issued_a[i]) if (issued_a[i] != K) all_out = 1'b0;
            foreach (issued_b[j]) if (issued_b[j] != K) all_out = 1'b0;
            if (all_out) begin
               m_busy   = 1'b0;
               exp_done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      check("busy",    64'(bus.busy),    64'(m_busy));
      check("done",    64'(bus.done),    64'(exp_done));
      check("a_valid", 64'(bus.a_valid), 64'(exp_av));
      check("a_data",  64'(bus.a_data),  64'(exp_a));
      check("b_valid", 64'(bus.b_valid), 64'(exp_bv));
      check("b_data",  64'(bus.b_data),  64'(exp_b));
`ifdef SYSTOLIC_SKEW_FEEDER_ERR_EN
      check("err",     64'(bus.err),     64'(m_err));
`endif
   endtask

   task automatic wr(input bit isb, input int lane, input int idx, input int data, input bit with_arm);
      bus.wr_en   = 1'b1;
      bus.wr_is_b = isb;
      bus.wr_lane = LW'(lane);
      bus.wr_idx  = IW'(idx);
      bus.wr_data = DW'(data);
      bus.arm     = with_arm;
      step();
      clr();
   endtask

   task automatic do_arm();
      bus.arm = 1'b1;
      step();
      clr();
   endtask

   // Issue loads with thermometer enables growing by one lane per load,
   // optional idle gap cycles and optional stray writes/arms, until the
   // model reports the tile fully issued (bounded).
   task automatic feed(input int p0, input int gap, input bit junk);
      int p;
      int guard;
      p = p0;
      guard = 0;
      while (m_busy && guard < 100) begin
         bus.load       = 1'b1;
         bus.A_start_en = therm_a(p);
         bus.B_start_en = therm_b(p);
         if (junk) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_is_b = 1'($urandom_range(0, 1));
            bus.wr_lane = LW'($urandom_range(0, 3));
            bus.wr_idx  = IW'($urandom_range(0, 3));
            bus.wr_data = DW'($urandom);
            bus.arm     = 1'($urandom_range(0, 1));
         end
         step();
         clr();
         p++;
         guard++;
         for (int g = 0; g < gap; g++) begin
            bus.A_start_en = N'($urandom);
            bus.B_start_en = M'($urandom);
            step();
            clr();
         end
      end
      check("feed_end_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      clr();
      m_busy = 1'b0;
      m_err  = 1'b0;
      foreach (bufa[i, k]) bufa[i][k] = 0;
      foreach (bufb[j, k]) bufb[j][k] = 0;
      foreach (issued_a[i]) issued_a[i] = 0;
      foreach (issued_b[j]) issued_b[j] = 0;

      // Reset held two cycles, then a load in IDLE must not issue.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      bus.load = 1'b1;
      bus.A_start_en = '1;
      bus.B_start_en = '1;
      step();
      clr();
      step();

      // Tiles: A row r word k = (r+1)*10+k+1, B column j = (j+3)*10+k+1.
      for (int r = 0; r < N; r++)
         for (int k = 0; k < K; k++) wr(1'b0, r, k, (r + 1) * 10 + k + 1, 1'b0);
      for (int j = 0; j < M; j++)
         for (int k = 0; k < K; k++) wr(1'b1, j, k, (j + 3) * 10 + k + 1, 1'b0);

      // Skewed feed: enables 0.., 1.., 11.., back-to-back loads.
      do_arm();
      feed(0, 0, 1'b0);
      step();

      // Loads separated by three idle cycles.
      do_arm();
      feed(1, 3, 1'b0);

      // Write while busy is dropped; a re-arm replays the old word.
      do_arm();
      bus.load = 1'b1; bus.A_start_en = '1; bus.B_start_en = '1;
      step();
      clr();
      wr(1'b0, 0, 0, 8'hEE, 1'b0);
      feed(N, 0, 1'b0);
      do_arm();
      feed(N, 0, 1'b0);

      // Reset after one load: no done, tile retained, re-arm restarts.
      do_arm();
      bus.load = 1'b1; bus.A_start_en = '1; bus.B_start_en = '1;
      step();
      clr();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      do_arm();
      feed(0, 1, 1'b0);

      // Out-of-range writes are dropped; same-cycle write+arm commits.
      wr(1'b0, N, 0, 8'hAA, 1'b0);
      wr(1'b1, M, 1, 8'hBB, 1'b0);
      wr(1'b0, 0, K, 8'hCC, 1'b0);
      feed(0, 0, 1'b0);
      wr(1'b0, N - 1, K - 1, 8'h77, 1'b1);
      feed(0, 0, 1'b0);

      // Randomized tiles, enable start points, gaps and stray traffic.
      for (int round = 0; round < 12; round++) begin
         int nw;
         nw = $urandom_range(0, 5);
         for (int w = 0; w < nw; w++)
            wr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 255), 1'b0);
         if ($urandom_range(0, 1) == 1)
            wr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 255), 1'b1);
         else
            do_arm();
         feed($urandom_range(0, N), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder sitting directly downstream of the systolic start-enable/load controller and directly upstream of the PE array. It holds one A tile (N rows × K words) and one B tile (M columns × K words). On each controller `load` pulse, every lane whose start enable is set emits its next word. The thermometer-shaped enables therefore produce the diagonal skew the array needs, with zeros injected elsewhere.

## Interface
- `N`, 2: A rows (array rows); ≥2
- `M`, 2: B columns (array columns); ≥2
- `K`, 2: inner dimension, words per lane; ≥1
- `DW`, 8: operand width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `A_start_en`  in  N  per-row start enables from controller
- `B_start_en`  in  M  per-column start enables from controller
- `load`  in  1  one-cycle advance pulse from controller
- `wr_en`  in  1  tile write strobe
- `wr_is_b`  in  1  0 = A buffer, 1 = B buffer
- `wr_lane`  in  clog2(max(N,M))  row (A) / column (B) index
- `wr_idx`  in  clog2(K) (min 1)  word index within lane
- `wr_data`  in  DW  word
- `arm`  in  1  start feeding the loaded tile
- `busy`  out  1  high in FEED
- `a_data`  out  N*DW  lane i at bits [i*DW +: DW]
- `a_valid`  out  N  per-row valid
- `b_data`  out  M*DW  per-column data
- `b_valid`  out  M  per-column valid
- `done`  out  1  one-cycle pulse, tile fully issued

## Operation
- States: IDLE, FEED. Reset enters IDLE.
- **IDLE:**
  - `wr_en` writes `wr_data` to buffer[`wr_is_b`][`wr_lane`][`wr_idx`].
  - `arm` moves to FEED next cycle and clears all lane counters to 0.
  - `load` is ignored.
- **FEED:**
  - Each A lane i keeps counter `cnt_a[i]` in 0..K; each B lane j keeps `cnt_b[j]`. Counter width is clog2(K+1).
  - On `load`, lane i issues when `A_start_en[i]`=1 and `cnt_a[i]`<K:
    - `a_data[i]` ← buffer word `cnt_a[i]`, `a_valid[i]`←1, and the counter increments.
    - B lanes follow the same rule.
  - A lane that is not issuing drives data 0 and valid 0. This covers enable low, exhausted lanes, and cycles with no `load`.
- **Completion:** when the load-cycle update leaves every counter at K, the block enters IDLE next cycle and pulses `done`.
- `wr_en` in FEED is dropped; the buffer is unchanged.
- `arm` in FEED is ignored.
- Out-of-range `wr_lane` (≥N for A, ≥M for B) or `wr_idx`≥K is dropped.
- Buffer storage is not reset; contents survive `rst`.
- The block does not time out. The controller guarantees all enables reach 1 within N−1 / M−1 loads.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0
  - `a_valid`=0, `b_valid`=0
  - `a_data`=0, `b_data`=0
  - all counters 0
- **`rst` mid-FEED:** the next cycle is IDLE with all outputs at reset values. No `done` pulse.
- **Registered outputs:** a `load` sampled at edge t produces data/valid during cycle t+1. They return to 0 at t+2 unless `load` is high again at t+1.
- **Completion timing:** `done` and `busy`=0 appear in the same cycle as the final valid words.
- **Enable sampling:** enables are sampled in the `load` cycle itself, i.e. the pre-update controller value.
- **Same-cycle write and arm in IDLE:** the write commits and is visible to the feed.
- **`arm` cycle:** a `load` in the same cycle is ignored. The first issuing load is at the earliest one cycle after `arm`.
- **Feed length:** minimum is K loads when all enables are already high.
- **K=1:** each lane issues exactly once.

## Configuration
- Macro: `SYSTOLIC_SKEW_FEEDER_ERR_EN`.
- **Defined:** adds output `err` (1 bit, reset 0).
  - `err` is sticky; it is set the cycle after any dropped write (write in FEED or out-of-range index).
  - It is cleared by `rst` or by an accepted `arm`.
- **Undefined:** port `err` is absent; dropped writes are silent. All other behaviour is identical.

## Structure
- **Shared package `systolic_pkg`:**
  - state enum (IDLE, FEED)
  - default DW
  - width helpers: lane-index width, word-index width, counter width clog2(K+1)
- **Sub-module `skew_feed_lane`** (one per A row and B column) contains:
  - the K×DW buffer and its write port
  - the counter
  - the registered data/valid output
  - an `exhausted` flag
- **Top level:**
  - instantiates N + M lanes
  - decodes writes
  - ANDs the `exhausted` flags for completion
  - runs the FSM

## Test plan
- **Reset:** hold `rst` 2 cycles → all outputs 0, `busy`=0; release, then `load` in IDLE → no valid.
- **Skewed feed, N=M=K=2:**
  - Setup: A rows = {11,12},{21,22}; B = {31,32},{41,42}; `arm`.
  - Loads with enables 00, 01, 11, 11, 11.
  - Expect `a_valid` sequence 00, 01, 11, 10, 00.
  - Expect row 0 data 11, 12; row 1 data 21, 22, one load behind.
  - `done` with the last word, then `busy`=0.
- **Gaps between loads:** insert 3 idle cycles between loads → valid is a 1-cycle pulse each time, and data is 0 in gap cycles.
- **Write while busy:** issue `wr_en` to A[0][0] mid-FEED → the feed still emits the old value, and a second `arm` emits the old value again. With `SYSTOLIC_SKEW_FEEDER_ERR_EN` defined, `err`=1.
- **Reset mid-FEED:** assert `rst` after 1 load → next cycle IDLE, no `done`. Re-`arm` then gives a full tile from word 0 with the buffer retained.
- **Out-of-range write:** `wr_lane`=N with `wr_is_b`=0 → no buffer change (verified by a subsequent feed). `err`=1 when the macro is defined.
